// File: rtl/string_art_pkg.sv
// Shared types and defaults for the string-art line selector and its pin ROM.
package string_art_pkg;

  localparam int NUM_PINS = 256;
  localparam int MIN_GAP  = 20;
  localparam int PIN_W    = 8;
  localparam int COORD_W  = 9;
  localparam int RED_W    = 19;

  localparam logic signed [RED_W-1:0] RED_MIN = {1'b1, {(RED_W-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    REQ,
    RESP,
    CHECK,
    CMT_LOOKUP,
    CMT_REQ,
    CMT_RESP,
    DONE
  } sel_state_t;

  typedef enum logic {
    MODE_EVAL   = 1'b0,
    MODE_COMMIT = 1'b1
  } sol_mode_t;

endpackage

// File: rtl/string_line_selector_pin_coord_rom.sv
// Dual-read synchronous ROM: pin index -> (x,y) on a radius-127 circle centred at (128,128).
module pin_coord_rom
  import string_art_pkg::*;
#(
  parameter int NUM_PINS = string_art_pkg::NUM_PINS,
  parameter int PIN_W    = string_art_pkg::PIN_W,
  parameter int COORD_W  = string_art_pkg::COORD_W
) (
  input  logic               clk,
  input  logic [PIN_W-1:0]   addr_a,
  input  logic [PIN_W-1:0]   addr_b,
  output logic [COORD_W-1:0] x_a,
  output logic [COORD_W-1:0] y_a,
  output logic [COORD_W-1:0] x_b,
  output logic [COORD_W-1:0] y_b
);

  localparam int ENTRY_W = 2 * COORD_W;

  // cos/sin of 2*pi/256 in Q30; the table is built by repeated fixed-point rotation
  localparam longint COS_Q30 = 64'sd1073418430;
  localparam longint SIN_Q30 = 64'sd26350944;

  function automatic logic [NUM_PINS*ENTRY_W-1:0] build_table();
    logic [NUM_PINS*ENTRY_W-1:0] tbl;
    longint x, y, nx, ny, px, py;
    tbl = '0;
    x = longint'(127) <<< 20;
    y = 0;
    for (int p = 0; p < NUM_PINS; p++) begin
      px = ((x + (longint'(1) <<< 19)) >>> 20) + 128;
      py = ((y + (longint'(1) <<< 19)) >>> 20) + 128;
      tbl[p*ENTRY_W +: ENTRY_W] = {COORD_W'(px), COORD_W'(py)};
      nx = (x * COS_Q30 - y * SIN_Q30) >>> 30;
      ny = (x * SIN_Q30 + y * COS_Q30) >>> 30;
      x = nx;
      y = ny;
    end
    return tbl;
  endfunction

  localparam logic [NUM_PINS*ENTRY_W-1:0] COORD_TABLE = build_table();

  always_ff @(posedge clk) begin
    {x_a, y_a} <= COORD_TABLE[int'(addr_a)*ENTRY_W +: ENTRY_W];
    {x_b, y_b} <= COORD_TABLE[int'(addr_b)*ENTRY_W +: ENTRY_W];
  end

endmodule

// File: rtl/string_line_selector.sv
// Greedy line chooser: sweeps legal destination pins through the solver, commits the best line.
// Optional cycle counter output perf_cycles is enabled with SELECTOR_PERF_CNT_EN.
module string_line_selector
  import string_art_pkg::*;
#(
  parameter int NUM_PINS = string_art_pkg::NUM_PINS,
  parameter int MIN_GAP  = string_art_pkg::MIN_GAP,
  parameter int PIN_W    = string_art_pkg::PIN_W,
  parameter int COORD_W  = string_art_pkg::COORD_W,
  parameter int RED_W    = string_art_pkg::RED_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_val,
  output logic                    cmd_rdy,
  input  logic [PIN_W-1:0]        cmd_pin,
  output logic                    sol_req_val,
  input  logic                    sol_req_rdy,
  output logic [COORD_W-1:0]      sol_req_p1_x,
  output logic [COORD_W-1:0]      sol_req_p1_y,
  output logic [COORD_W-1:0]      sol_req_p2_x,
  output logic [COORD_W-1:0]      sol_req_p2_y,
  output logic                    sol_change,
  output logic                    sol_mode,
  input  logic                    sol_resp_val,
  output logic                    sol_resp_rdy,
  input  logic signed [RED_W-1:0] sol_resp_reduction,
  output logic                    res_val,
  input  logic                    res_rdy,
  output logic [PIN_W-1:0]        res_pin,
  output logic signed [RED_W-1:0] res_reduction,
  output logic                    res_found
`ifdef SELECTOR_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam logic signed [RED_W-1:0] BEST_INIT = {1'b1, {(RED_W-1){1'b0}}};

  sel_state_t              state;
  sol_mode_t               mode;
  logic                    lookup_phase;
  logic [PIN_W-1:0]        cur;
  logic [PIN_W-1:0]        cand;
  logic [PIN_W-1:0]        best_pin;
  logic [PIN_W-1:0]        last_cand;
  logic [PIN_W-1:0]        rom_addr_b;
  logic signed [RED_W-1:0] best;
  logic [COORD_W-1:0]      rom_x_a, rom_y_a, rom_x_b, rom_y_b;
  logic [COORD_W-1:0]      dx, dy;
  logic                    steep;

  assign rom_addr_b = (state == CMT_LOOKUP) ? best_pin : cand;
  assign last_cand  = cur - PIN_W'(MIN_GAP);
  assign sol_mode   = mode;

  pin_coord_rom #(
    .NUM_PINS(NUM_PINS),
    .PIN_W   (PIN_W),
    .COORD_W (COORD_W)
  ) u_rom (
    .clk   (clk),
    .addr_a(cur),
    .addr_b(rom_addr_b),
    .x_a   (rom_x_a),
    .y_a   (rom_y_a),
    .x_b   (rom_x_b),
    .y_b   (rom_y_b)
  );

  // Unsigned distances, larger minus smaller, decide whether the axes are swapped
  always_comb begin
    dx    = (rom_x_b >= rom_x_a) ? rom_x_b - rom_x_a : rom_x_a - rom_x_b;
    dy    = (rom_y_b >= rom_y_a) ? rom_y_b - rom_y_a : rom_y_a - rom_y_b;
    steep = dy > dx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      mode          <= MODE_EVAL;
      lookup_phase  <= 1'b0;
      cur           <= '0;
      cand          <= '0;
      best_pin      <= '0;
      best          <= '0;
      cmd_rdy       <= 1'b1;
      sol_req_val   <= 1'b0;
      sol_resp_rdy  <= 1'b0;
      sol_change    <= 1'b0;
      sol_req_p1_x  <= '0;
      sol_req_p1_y  <= '0;
      sol_req_p2_x  <= '0;
      sol_req_p2_y  <= '0;
      res_val       <= 1'b0;
      res_pin       <= '0;
      res_reduction <= '0;
      res_found     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_val) begin
            cur          <= cmd_pin;
            cand         <= cmd_pin + PIN_W'(MIN_GAP);
            best_pin     <= cmd_pin + PIN_W'(MIN_GAP);
            best         <= BEST_INIT;
            cmd_rdy      <= 1'b0;
            mode         <= MODE_EVAL;
            lookup_phase <= 1'b0;
            state        <= LOOKUP;
          end
        end
        // First cycle presents the ROM address, second cycle captures the coordinates
        LOOKUP, CMT_LOOKUP: begin
          if (!lookup_phase) begin
            lookup_phase <= 1'b1;
          end else begin
            lookup_phase <= 1'b0;
            sol_change   <= steep;
            if (steep) begin
              sol_req_p1_x <= rom_y_a;
              sol_req_p1_y <= rom_x_a;
              sol_req_p2_x <= rom_y_b;
              sol_req_p2_y <= rom_x_b;
            end else begin
              sol_req_p1_x <= rom_x_a;
              sol_req_p1_y <= rom_y_a;
              sol_req_p2_x <= rom_x_b;
              sol_req_p2_y <= rom_y_b;
            end
            sol_req_val <= 1'b1;
            if (state == LOOKUP) begin
              mode  <= MODE_EVAL;
              state <= REQ;
            end else begin
              mode  <= MODE_COMMIT;
              state <= CMT_REQ;
            end
          end
        end
        REQ, CMT_REQ: begin
          if (sol_req_rdy) begin
            sol_req_val  <= 1'b0;
            sol_resp_rdy <= 1'b1;
            state        <= (state == REQ) ? RESP : CMT_RESP;
          end
        end
        RESP: begin
          if (sol_resp_val) begin
            sol_resp_rdy <= 1'b0;
            if (sol_resp_reduction > best) begin
              best     <= sol_resp_reduction;
              best_pin <= cand;
            end
            if (cand == last_cand) begin
              state <= CHECK;
            end else begin
              cand  <= cand + 1'b1;
              state <= LOOKUP;
            end
          end
        end
        CHECK: begin
          if (!best[RED_W-1] && best != '0) begin
            state <= CMT_LOOKUP;
          end else begin
            res_val       <= 1'b1;
            res_pin       <= best_pin;
            res_reduction <= best;
            res_found     <= 1'b0;
            state         <= DONE;
          end
        end
        // The commit response carries nothing useful; only the handshake matters
        CMT_RESP: begin
          if (sol_resp_val) begin
            sol_resp_rdy  <= 1'b0;
            res_val       <= 1'b1;
            res_pin       <= best_pin;
            res_reduction <= best;
            res_found     <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (res_rdy) begin
            res_val <= 1'b0;
            cmd_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SELECTOR_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles <= '0;
    end else if (state == IDLE && cmd_val) begin
      perf_cycles <= '0;
    end else if (state != IDLE && state != DONE && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_string_line_selector.sv
// Directed bench for string_line_selector with a behavioural solver responder.
module tb_string_line_selector;
  import string_art_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic cmd_val, cmd_rdy;
  logic [PIN_W-1:0] cmd_pin;
  logic sol_req_val, sol_req_rdy;
  logic [COORD_W-1:0] sol_req_p1_x, sol_req_p1_y, sol_req_p2_x, sol_req_p2_y;
  logic sol_change, sol_mode;
  logic sol_resp_val, sol_resp_rdy;
  logic signed [RED_W-1:0] sol_resp_reduction;
  logic res_val, res_rdy;
  logic [PIN_W-1:0] res_pin;
  logic signed [RED_W-1:0] res_reduction;
  logic res_found;
`ifdef SELECTOR_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  string_line_selector dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_val           (cmd_val),
    .cmd_rdy           (cmd_rdy),
    .cmd_pin           (cmd_pin),
    .sol_req_val       (sol_req_val),
    .sol_req_rdy       (sol_req_rdy),
    .sol_req_p1_x      (sol_req_p1_x),
    .sol_req_p1_y      (sol_req_p1_y),
    .sol_req_p2_x      (sol_req_p2_x),
    .sol_req_p2_y      (sol_req_p2_y),
    .sol_change        (sol_change),
    .sol_mode          (sol_mode),
    .sol_resp_val      (sol_resp_val),
    .sol_resp_rdy      (sol_resp_rdy),
    .sol_resp_reduction(sol_resp_reduction),
    .res_val           (res_val),
    .res_rdy           (res_rdy),
    .res_pin           (res_pin),
    .res_reduction     (res_reduction),
`ifdef SELECTOR_PERF_CNT_EN
    .perf_cycles       (perf_cycles),
`endif
    .res_found         (res_found)
  );

  int checks = 0;
  int passes = 0;

  // Knobs written by the stimulus process, read by the solver model
  logic signed [RED_W-1:0] red_tab [NUM_PINS];
  logic hold_resp = 1'b0;
  logic stale     = 1'b0;
  logic bp_mode   = 1'b0;

  // Counters written only by the solver model
  int eval_cnt = 0, cmt_cnt = 0, stable_viol = 0, overlap_viol = 0;
  int steep_viol = 0, ring_viol = 0, p1_viol = 0, pos_viol = 0, cmt_viol = 0, stale_fires = 0;
  logic [2*COORD_W-1:0] seen_p2 [NUM_PINS];
  bit                   seen_ok [NUM_PINS];

  function automatic int ring_bad(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    int ddx, ddy, r2;
    ddx = int'(x) - 128;
    ddy = int'(y) - 128;
    r2  = ddx * ddx + ddy * ddy;
    return (r2 < 120 * 120 || r2 > 133 * 133) ? 1 : 0;
  endfunction

  initial begin : solver_model
    int idx, bp_wait;
    logic pending, resp_fire, prev_wait, run_p1_ok;
    logic [PIN_W-1:0] start_pin, mcand, mbest_pin;
    logic signed [RED_W-1:0] mbest, resp_value;
    logic [4*COORD_W+1:0] cur_fields, prev_fields;
    logic [COORD_W-1:0] ax, ay, bx, by, ddx, ddy;
    logic [2*COORD_W-1:0] run_p1;
    idx = 0; bp_wait = 0; pending = 0; resp_fire = 0; prev_wait = 0; run_p1_ok = 0;
    start_pin = '0; mbest_pin = '0; mbest = RED_MIN; resp_value = '0; prev_fields = '0; run_p1 = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      seen_ok[i] = 0;
      seen_p2[i] = '0;
    end
    sol_req_rdy = 1'b1; sol_resp_val = 1'b0; sol_resp_reduction = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        pending = 0; resp_fire = 0; prev_wait = 0; sol_resp_val = 1'b0;
      end else begin
        if (cmd_val && cmd_rdy) begin
          idx = 0; start_pin = cmd_pin; mbest = RED_MIN;
          mbest_pin = cmd_pin + PIN_W'(MIN_GAP); run_p1_ok = 0;
        end
        if (resp_fire) begin
          sol_resp_val = 1'b0; pending = 0; resp_fire = 0;
        end
        if (stale) begin
          sol_resp_val = 1'b1;
          sol_resp_reduction = 19'sd99;
          if (sol_resp_rdy) stale_fires++;
        end else begin
          if (!pending) sol_resp_val = 1'b0;
          if (pending && !hold_resp && !sol_resp_val) begin
            sol_resp_val = 1'b1;
            sol_resp_reduction = resp_value;
          end
          resp_fire = sol_resp_val && sol_resp_rdy;
        end
        if (bp_mode) begin
          if (!sol_req_val) bp_wait = 0;
          sol_req_rdy = (bp_wait >= 5) ? 1'($urandom_range(0, 1)) : 1'b0;
          if (sol_req_val) bp_wait++;
        end else begin
          sol_req_rdy = 1'b1;
        end
        cur_fields = {sol_mode, sol_change, sol_req_p1_x, sol_req_p1_y, sol_req_p2_x, sol_req_p2_y};
        if (prev_wait && (!sol_req_val || cur_fields != prev_fields)) stable_viol++;
        if (sol_req_val && sol_resp_rdy) overlap_viol++;
        if (sol_req_val && sol_req_rdy) begin
          if (sol_change) begin
            ax = sol_req_p1_y; ay = sol_req_p1_x; bx = sol_req_p2_y; by = sol_req_p2_x;
          end else begin
            ax = sol_req_p1_x; ay = sol_req_p1_y; bx = sol_req_p2_x; by = sol_req_p2_y;
          end
          ddx = (bx >= ax) ? bx - ax : ax - bx;
          ddy = (by >= ay) ? by - ay : ay - by;
          if ((ddy > ddx) != sol_change) steep_viol++;
          ring_viol += ring_bad(ax, ay) + ring_bad(bx, by);
          if (!run_p1_ok) begin
            run_p1 = {ax, ay}; run_p1_ok = 1;
          end else if ({ax, ay} != run_p1) begin
            p1_viol++;
          end
          if (!sol_mode) begin
            mcand = PIN_W'(int'(start_pin) + MIN_GAP + idx);
            if (seen_ok[mcand] && seen_p2[mcand] != {bx, by}) pos_viol++;
            seen_p2[mcand] = {bx, by};
            seen_ok[mcand] = 1;
            resp_value = red_tab[mcand];
            if (red_tab[mcand] > mbest) begin
              mbest = red_tab[mcand]; mbest_pin = mcand;
            end
            idx++;
            eval_cnt++;
          end else begin
            cmt_cnt++;
            if (!seen_ok[mbest_pin] || seen_p2[mbest_pin] != {bx, by}) cmt_viol++;
            resp_value = 19'sd77;
          end
          pending = 1;
          prev_wait = 0;
        end else begin
          prev_wait = sol_req_val;
        end
        prev_fields = cur_fields;
      end
    end
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic fillTable(input logic signed [RED_W-1:0] value);
    for (int i = 0; i < NUM_PINS; i++) red_tab[i] = value;
  endtask

  task automatic applyStimulus(input logic [PIN_W-1:0] pin);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!cmd_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("cmd_rdy_idle", cmd_rdy, 1);
    cmd_pin = pin;
    cmd_val = 1'b1;
    @(negedge clk);
    cmd_val = 1'b0;
    checkOutput("cmd_rdy_busy", cmd_rdy, 0);
  endtask

  task automatic runCase(input string name, input logic [PIN_W-1:0] pin, input longint exp_pin,
                         input longint exp_red, input longint exp_found, input int exp_cmts,
                         input longint exp_perf);
    int e0, c0, v0, g0, m0, waited;
    e0 = eval_cnt; c0 = cmt_cnt; v0 = stable_viol + overlap_viol;
    g0 = steep_viol + ring_viol + p1_viol + pos_viol; m0 = cmt_viol;
    applyStimulus(pin);
    waited = 0;
    while (!res_val && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({name, "_res_val"}, res_val, 1);
    checkOutput({name, "_res_pin"}, res_pin, exp_pin);
    checkOutput({name, "_res_reduction"}, res_reduction, exp_red);
    checkOutput({name, "_res_found"}, res_found, exp_found);
`ifdef SELECTOR_PERF_CNT_EN
    if (exp_perf >= 0) checkOutput({name, "_perf"}, perf_cycles, exp_perf);
`endif
    @(negedge clk);
    checkOutput({name, "_res_hold"}, res_val, 1);
`ifdef SELECTOR_PERF_CNT_EN
    if (exp_perf >= 0) checkOutput({name, "_perf_hold"}, perf_cycles, exp_perf);
`endif
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    checkOutput({name, "_res_release"}, res_val, 0);
    checkOutput({name, "_evals"}, eval_cnt - e0, 217);
    checkOutput({name, "_commits"}, cmt_cnt - c0, exp_cmts);
    checkOutput({name, "_req_protocol"}, stable_viol + overlap_viol - v0, 0);
    checkOutput({name, "_geometry"}, steep_viol + ring_viol + p1_viol + pos_viol - g0, 0);
    checkOutput({name, "_commit_line"}, cmt_viol - m0, 0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_cmd_rdy"}, cmd_rdy, 1);
    checkOutput({name, "_req_val"}, sol_req_val, 0);
    checkOutput({name, "_resp_rdy"}, sol_resp_rdy, 0);
    checkOutput({name, "_res_val"}, res_val, 0);
    checkOutput({name, "_res_pin"}, res_pin, 0);
    checkOutput({name, "_res_reduction"}, res_reduction, 0);
    checkOutput({name, "_res_found"}, res_found, 0);
    checkOutput({name, "_mode"}, sol_mode, 0);
  endtask

  initial begin : stimulus
    int c0, s0, waited;
    reset = 1'b0; cmd_val = 1'b0; cmd_pin = '0; res_rdy = 1'b0;
    fillTable(-19'sd1);
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b1;

    fillTable(-19'sd1);
    red_tab[100] = 19'sd5;
    runCase("single_peak", 8'd0, 100, 5, 1, 1, 873);

    fillTable(-19'sd3);
    runCase("all_negative", 8'd10, 30, -3, 0, 0, -1);

    fillTable(-19'sd1);
    red_tab[50] = 19'sd7;
    red_tab[60] = 19'sd7;
    runCase("tie", 8'd0, 50, 7, 1, 1, -1);

    bp_mode = 1'b1;
    fillTable(-19'sd1);
    red_tab[200] = 19'sd12;
    runCase("backpressure", 8'd128, 200, 12, 1, 1, -1);
    bp_mode = 1'b0;

    fillTable(-19'sd2);
    red_tab[14] = 19'sd9;
    red_tab[5]  = 19'sd9;
    red_tab[230] = 19'sd4;
    runCase("wrap", 8'd250, 14, 9, 1, 1, -1);

    fillTable(-19'sd4);
    red_tab[150] = 19'sd0;
    runCase("zero_best", 8'd64, 150, 0, 0, 0, -1);

    fillTable(RED_MIN);
    runCase("red_min", 8'd3, 23, -262144, 0, 0, -1);

    // Abort in RESP with the response withheld, then offer a stale response
    fillTable(19'sd50);
    hold_resp = 1'b1;
    c0 = cmt_cnt;
    s0 = stale_fires;
    applyStimulus(8'd0);
    waited = 0;
    while (!sol_resp_rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reach_resp", sol_resp_rdy, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hold_resp = 1'b0;
    checkResetState("abort");
    stale = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stale_resp_rdy", sol_resp_rdy, 0);
    end
    stale = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("stale_consumed", stale_fires - s0, 0);
    checkOutput("abort_no_commit", cmt_cnt - c0, 0);
    checkOutput("abort_idle", cmd_rdy, 1);
    checkOutput("abort_no_result", res_val, 0);

    fillTable(-19'sd3);
    red_tab[40] = 19'sd1;
    runCase("recovery", 8'd10, 40, 1, 1, 1, -1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
